rx_window_ctrl: RTL and testbench
=================================

// Module: rx_window_ctrl
// PURPOSE
//   Sequences strobe_gen for radar receive windows. On each IPP sync edge, waits a
//   programmable delay, enables strobe_gen for exactly N output strobes, then
//   disables it. Rate/delay/sample-count config is shadowed and applied only at a
//   sync edge, so strobe_gen never sees a rate change mid-window.
// PARAMETERS
//   DW  16  width of delay and sample counters, and of windows_count
//   RW  8   width of rate (matches strobe_gen rate port)
// PORTS
//   clock          in   1   system clock; all logic on rising edge
//   reset          in   1   synchronous, active-high
//   ctrl_enable    in   1   master enable; low forces IDLE
//   sync_in        in   1   IPP trigger, already in clock domain; rising edge acts
//   cfg_load       in   1   1-cycle pulse: capture cfg_* into shadow regs
//   cfg_rate       in   RW  strobe_gen rate for next window
//   cfg_delay      in   DW  clocks from sync edge to window start
//   cfg_samples    in   DW  strobes per window; 0 = window suppressed
//   overrun_clr    in   1   clears overrun
//   gen_strobe     in   1   strobe output of strobe_gen
//   gen_enable     out  1   enable to strobe_gen
//   gen_rate       out  RW  rate to strobe_gen; changes only while gen_enable=0
//   window_active  out  1   high in DELAY or ACTIVE
//   window_done    out  1   1-cycle pulse at end of a completed window
//   overrun        out  1   sticky: sync edge arrived while window in progress
//   windows_count  out  DW  completed windows, wraps 2^DW-1 -> 0
//   dbus           out  16  debug {state[2:0],gen_enable,gen_strobe,sync_in,
//                           overrun,window_done,samp_cnt[7:0]}
// BEHAVIOUR
//   Reset: state IDLE; all outputs, shadow regs, counters, sync_d = 0.
//   Edge: sync_edge = sync_in & ~sync_d; sync_d registered every cycle incl. IDLE.
//   States: IDLE, ARMED, DELAY, ACTIVE.
//   - IDLE: ctrl_enable=1 -> ARMED next cycle.
//   - ARMED: on sync_edge at cycle T: gen_rate<=shadow_rate, delay_cnt<=shadow_delay,
//     samp_cnt<=shadow_samples. shadow_samples=0 -> stay ARMED, nothing else happens.
//     Else delay=0 -> ACTIVE, gen_enable=1 at T+1; else DELAY.
//   - DELAY: delay_cnt decrements per cycle; gen_enable rises at exactly T+1+D
//     (D=shadow_delay), entering ACTIVE that cycle.
//   - ACTIVE: each cycle gen_strobe=1 decrements samp_cnt. On gen_strobe with
//     samp_cnt=1: gen_enable=0, window_done=1 next cycle (1 cycle only),
//     windows_count+1, -> ARMED. gen_strobe ignored outside ACTIVE.
//   - cfg_load: any state, shadow regs <= cfg_* next cycle; active copies untouched.
//     cfg_load and sync_edge same cycle: window uses OLD shadow; new values next window.
//   - sync_edge in DELAY/ACTIVE: ignored for sequencing, overrun<=1 (sticky).
//     overrun_clr clears; set wins over clear in same cycle.
//   - ctrl_enable=0 in any state: -> IDLE next cycle, gen_enable=0, delay/samp cnt
//     cleared, no window_done, windows_count/overrun/shadow/gen_rate held.
//   - reset mid-window: same as power-up reset (gen_enable=0 next cycle).
//   - Back-to-back: sync_edge in the cycle window_done asserts (ARMED) starts a
//     new window; not an overrun.
// TESTING
//   1 rate=3,delay=10,samples=4, one sync -> gen_enable high T+11, low the cycle
//     after 4th gen_strobe; window_done one pulse; windows_count=1.
//   2 delay=0,samples=1 -> gen_enable high T+1 for one strobe only; done pulse.
//   3 cfg_load rate=7 during ACTIVE (rate=3) -> gen_rate stays 3 until next sync
//     edge, then 7; cfg_load coincident with sync -> old values used.
//   4 second sync edge during DELAY -> overrun=1, window timing unchanged;
//     overrun_clr -> 0; simultaneous set+clr -> 1.
//   5 ctrl_enable drop mid-ACTIVE -> gen_enable 0 next cycle, no window_done,
//     count unchanged; samples=0 sync -> no enable, no overrun.
//   6 preload windows_count 0xFFFF via 65535 short windows -> wraps to 0.

Source files
------------

// File: rtl/rx_window_if.sv
// Handshake/config/status bundle between rx_window_ctrl and its controller and strobe_gen.
interface rx_window_if #(
   parameter int DW = 16,
   parameter int RW = 8
);
   logic          ctrl_enable;
   logic          sync_in;
   logic          cfg_load;
   logic [RW-1:0] cfg_rate;
   logic [DW-1:0] cfg_delay;
   logic [DW-1:0] cfg_samples;
   logic          overrun_clr;
   logic          gen_strobe;
   logic          gen_enable;
   logic [RW-1:0] gen_rate;
   logic          window_active;
   logic          window_done;
   logic          overrun;
   logic [DW-1:0] windows_count;
   logic [15:0]   dbus;

   modport master (
      output ctrl_enable, sync_in, cfg_load, cfg_rate, cfg_delay, cfg_samples,
             overrun_clr, gen_strobe,
      input  gen_enable, gen_rate, window_active, window_done, overrun,
             windows_count, dbus
   );

   modport slave (
      input  ctrl_enable, sync_in, cfg_load, cfg_rate, cfg_delay, cfg_samples,
             overrun_clr, gen_strobe,
      output gen_enable, gen_rate, window_active, window_done, overrun,
             windows_count, dbus
   );
endinterface

// File: rtl/rx_window_ctrl.sv
// Receive-window sequencer for strobe_gen: sync edge -> programmable delay -> N strobes
// with gen_enable high -> disable. Config is shadowed and only applied at a sync edge.
module rx_window_ctrl #(
   parameter int DW = 16,
   parameter int RW = 8
) (
   input  logic       clock,
   input  logic       reset,
   rx_window_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARMED  = 3'd1,
      ST_DELAY  = 3'd2,
      ST_ACTIVE = 3'd3
   } state_t;

   localparam logic [DW-1:0] CNT_ONE = DW'(1);

   state_t        state_q, state_d;
   logic          sync_prev_q, sync_prev_d;
   logic [RW-1:0] shadow_rate_q, shadow_rate_d;
   logic [DW-1:0] shadow_delay_q, shadow_delay_d;
   logic [DW-1:0] shadow_samples_q, shadow_samples_d;
   logic [RW-1:0] gen_rate_q, gen_rate_d;
   logic [DW-1:0] delay_cnt_q, delay_cnt_d;
   logic [DW-1:0] samp_cnt_q, samp_cnt_d;
   logic [DW-1:0] windows_count_q, windows_count_d;
   logic          gen_enable_q, gen_enable_d;
   logic          window_active_q, window_active_d;
   logic          window_done_q, window_done_d;
   logic          overrun_q, overrun_d;
   logic          sync_edge;
   logic          in_window;

   assign sync_edge = bus.sync_in & ~sync_prev_q;
   assign in_window = (state_q == ST_DELAY) || (state_q == ST_ACTIVE);

   always_comb begin
      state_d          = state_q;
      sync_prev_d      = bus.sync_in;
      shadow_rate_d    = shadow_rate_q;
      shadow_delay_d   = shadow_delay_q;
      shadow_samples_d = shadow_samples_q;
      gen_rate_d       = gen_rate_q;
      delay_cnt_d      = delay_cnt_q;
      samp_cnt_d       = samp_cnt_q;
      windows_count_d  = windows_count_q;
      gen_enable_d     = gen_enable_q;
      window_done_d    = 1'b0;
      overrun_d        = overrun_q & ~bus.overrun_clr;

      // Shadow capture never touches the active copies; a coincident sync edge sees old values.
      if (bus.cfg_load) begin
         shadow_rate_d    = bus.cfg_rate;
         shadow_delay_d   = bus.cfg_delay;
         shadow_samples_d = bus.cfg_samples;
      end

      if (!bus.ctrl_enable) begin
         state_d      = ST_IDLE;
         gen_enable_d = 1'b0;
         delay_cnt_d  = '0;
         samp_cnt_d   = '0;
      end else begin
         if (in_window && sync_edge) overrun_d = 1'b1;
         case (state_q)
            ST_IDLE: state_d = ST_ARMED;
            ST_ARMED: begin
               if (sync_edge) begin
                  gen_rate_d  = shadow_rate_q;
                  delay_cnt_d = shadow_delay_q;
                  samp_cnt_d  = shadow_samples_q;
                  if (shadow_samples_q != '0) begin
                     if (shadow_delay_q == '0) begin
                        state_d      = ST_ACTIVE;
                        gen_enable_d = 1'b1;
                     end else begin
                        state_d = ST_DELAY;
                     end
                  end
               end
            end
            ST_DELAY: begin
               delay_cnt_d = delay_cnt_q - CNT_ONE;
               if (delay_cnt_q == CNT_ONE) begin
                  state_d      = ST_ACTIVE;
                  gen_enable_d = 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (bus.gen_strobe) begin
                  samp_cnt_d = samp_cnt_q - CNT_ONE;
                  if (samp_cnt_q == CNT_ONE) begin
                     state_d         = ST_ARMED;
                     gen_enable_d    = 1'b0;
                     window_done_d   = 1'b1;
                     windows_count_d = windows_count_q + CNT_ONE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      window_active_d = (state_d == ST_DELAY) || (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         sync_prev_q      <= 1'b0;
         shadow_rate_q    <= '0;
         shadow_delay_q   <= '0;
         shadow_samples_q <= '0;
         gen_rate_q       <= '0;
         delay_cnt_q      <= '0;
         samp_cnt_q       <= '0;
         windows_count_q  <= '0;
         gen_enable_q     <= 1'b0;
         window_active_q  <= 1'b0;
         window_done_q    <= 1'b0;
         overrun_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         sync_prev_q      <= sync_prev_d;
         shadow_rate_q    <= shadow_rate_d;
         shadow_delay_q   <= shadow_delay_d;
         shadow_samples_q <= shadow_samples_d;
         gen_rate_q       <= gen_rate_d;
         delay_cnt_q      <= delay_cnt_d;
         samp_cnt_q       <= samp_cnt_d;
         windows_count_q  <= windows_count_d;
         gen_enable_q     <= gen_enable_d;
         window_active_q  <= window_active_d;
         window_done_q    <= window_done_d;
         overrun_q        <= overrun_d;
      end
   end

   assign bus.gen_enable    = gen_enable_q;
   assign bus.gen_rate      = gen_rate_q;
   assign bus.window_active = window_active_q;
   assign bus.window_done   = window_done_q;
   assign bus.overrun       = overrun_q;
   assign bus.windows_count = windows_count_q;
   assign bus.dbus          = {state_q, gen_enable_q, bus.gen_strobe, bus.sync_in,
                               overrun_q, window_done_q, samp_cnt_q[7:0]};

endmodule

// File: tb/tb_rx_window_ctrl.sv
// Bench for rx_window_ctrl: vector table, directed window scenarios, counter wrap on a
// narrow instance, and randomized traffic against a timeline-based window model.
module tb_rx_window_ctrl;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   rx_window_if #(.DW(16), .RW(8)) bus ();
   rx_window_if #(.DW(8),  .RW(8)) wbus ();

   rx_window_ctrl #(.DW(16), .RW(8)) dut (.clock(clock), .reset(reset), .bus(bus));
   rx_window_ctrl #(.DW(8),  .RW(8)) dut_w (.clock(clock), .reset(reset), .bus(wbus));

   int n_checks = 0;
   int n_fail   = 0;

   // Window model: a window is a start cycle plus a count of strobes still owed.
   int       m_cyc;
   bit       m_live, m_busy, m_done, m_ov, m_sync_prev;
   int       m_win_start, m_left, m_count;
   int       m_sh_d, m_sh_n;
   bit [7:0] m_sh_rate, m_rate;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, m_cyc);
      end
   endtask

   task automatic model_reset();
      m_cyc = 0; m_live = 0; m_busy = 0; m_done = 0; m_ov = 0; m_sync_prev = 0;
      m_win_start = 0; m_left = 0; m_count = 0; m_sh_d = 0; m_sh_n = 0;
      m_sh_rate = '0; m_rate = '0;
   endtask

   task automatic model_step();
      bit edge_s, ov_set;
      edge_s = bus.sync_in && !m_sync_prev;
      ov_set = bus.ctrl_enable && m_busy && edge_s;
      m_done = 0;
      if (!bus.ctrl_enable) begin
         m_live = 0;
         m_busy = 0;
      end else if (!m_live) begin
         m_live = 1;
      end else if (!m_busy) begin
         if (edge_s) begin
            m_rate = m_sh_rate;
            if (m_sh_n != 0) begin
               m_busy = 1;
               m_win_start = m_cyc + 1 + m_sh_d;
               m_left = m_sh_n;
            end
         end
      end else if (m_cyc >= m_win_start && bus.gen_strobe) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 0;
            m_done = 1;
            m_count = (m_count + 1) % 65536;
         end
      end
      m_ov = ov_set || (m_ov && !bus.overrun_clr);
      if (bus.cfg_load) begin
         m_sh_rate = bus.cfg_rate;
         m_sh_d = int'(bus.cfg_delay);
         m_sh_n = int'(bus.cfg_samples);
      end
      m_sync_prev = bus.sync_in;
   endtask

   task automatic model_check();
      int samp;
      samp = m_busy ? (m_left % 256) : 0;
      chk("gen_enable", int'(bus.gen_enable), int'(m_busy && (m_cyc >= m_win_start)));
      chk("window_active", int'(bus.window_active), int'(m_busy));
      chk("window_done", int'(bus.window_done), int'(m_done));
      chk("overrun", int'(bus.overrun), int'(m_ov));
      chk("gen_rate", int'(bus.gen_rate), int'(m_rate));
      chk("windows_count", int'(bus.windows_count), m_count);
      chk("dbus_samp", int'(bus.dbus[7:0]), samp);
      chk("dbus_inputs", int'(bus.dbus[11:10]), int'({bus.gen_strobe, bus.sync_in}));
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      m_cyc++;
      model_check();
      bus.cfg_load = 1'b0;
      bus.overrun_clr = 1'b0;
   endtask

   task automatic set_in(input bit en, input bit sync, input bit strobe);
      bus.ctrl_enable = en;
      bus.sync_in = sync;
      bus.gen_strobe = strobe;
   endtask

   task automatic load_cfg(input bit [7:0] r, input bit [15:0] d, input bit [15:0] n);
      bus.cfg_load = 1'b1;
      bus.cfg_rate = r;
      bus.cfg_delay = d;
      bus.cfg_samples = n;
      tick();
   endtask

   typedef struct {
      bit en, sync, strobe;
      bit x_en, x_act, x_done, x_ov;
      int x_cnt;
   } vec_t;
   vec_t tbl[13];

   initial begin
      int k, ns, nd, g;
      tbl[0]  = '{1,0,0, 0,0,0,0, 0};
      tbl[1]  = '{1,1,0, 1,1,0,0, 0};
      tbl[2]  = '{1,1,0, 1,1,0,0, 0};
      tbl[3]  = '{1,0,1, 0,0,1,0, 1};
      tbl[4]  = '{1,0,1, 0,0,0,0, 1};
      tbl[5]  = '{1,1,0, 1,1,0,0, 1};
      tbl[6]  = '{1,0,1, 0,0,1,0, 2};
      tbl[7]  = '{1,1,1, 1,1,0,0, 2};
      tbl[8]  = '{1,1,0, 1,1,0,0, 2};
      tbl[9]  = '{1,0,0, 1,1,0,0, 2};
      tbl[10] = '{1,1,0, 1,1,0,1, 2};
      tbl[11] = '{0,0,1, 0,0,0,1, 2};
      tbl[12] = '{1,0,0, 0,0,0,1, 2};

      reset = 1'b1;
      set_in(0, 0, 0);
      bus.cfg_load = 0; bus.cfg_rate = '0; bus.cfg_delay = '0; bus.cfg_samples = '0;
      bus.overrun_clr = 0;
      wbus.ctrl_enable = 0; wbus.sync_in = 0; wbus.cfg_load = 0; wbus.cfg_rate = '0;
      wbus.cfg_delay = '0; wbus.cfg_samples = '0; wbus.overrun_clr = 0; wbus.gen_strobe = 0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_gen_enable", int'(bus.gen_enable), 0);
      chk("rst_gen_rate", int'(bus.gen_rate), 0);
      chk("rst_window_active", int'(bus.window_active), 0);
      chk("rst_window_done", int'(bus.window_done), 0);
      chk("rst_overrun", int'(bus.overrun), 0);
      chk("rst_windows_count", int'(bus.windows_count), 0);
      chk("rst_dbus", int'(bus.dbus), 0);
      model_reset();
      reset = 1'b0;

      // Vector table: delay 0, one strobe per window.
      bus.ctrl_enable = 1'b1;
      load_cfg(8'd5, 16'd0, 16'd1);
      for (int i = 0; i < 13; i++) begin
         set_in(tbl[i].en, tbl[i].sync, tbl[i].strobe);
         tick();
         chk($sformatf("tbl%0d_gen_enable", i), int'(bus.gen_enable), int'(tbl[i].x_en));
         chk($sformatf("tbl%0d_active", i), int'(bus.window_active), int'(tbl[i].x_act));
         chk($sformatf("tbl%0d_done", i), int'(bus.window_done), int'(tbl[i].x_done));
         chk($sformatf("tbl%0d_overrun", i), int'(bus.overrun), int'(tbl[i].x_ov));
         chk($sformatf("tbl%0d_count", i), int'(bus.windows_count), tbl[i].x_cnt);
      end

      // rate 3, delay 10, four strobes.
      bus.overrun_clr = 1'b1;
      load_cfg(8'd3, 16'd10, 16'd4);
      set_in(1, 0, 0); tick();
      set_in(1, 1, 0); tick();
      k = 1;
      while (!bus.gen_enable && k < 40) begin tick(); k++; end
      chk("t1_enable_latency", k, 11);
      chk("t1_gen_rate", int'(bus.gen_rate), 3);
      ns = 0; nd = 0; g = 0;
      while (bus.gen_enable && g < 40) begin
         bus.gen_strobe = g[0];
         if (bus.gen_strobe) ns++;
         tick();
         g++;
         if (bus.window_done) nd++;
      end
      bus.gen_strobe = 1'b0;
      tick();
      if (bus.window_done) nd++;
      chk("t1_strobes", ns, 4);
      chk("t1_done_pulses", nd, 1);
      chk("t1_count", int'(bus.windows_count), 3);

      // Rate change mid-window is deferred; coincident load uses old shadow.
      load_cfg(8'd3, 16'd2, 16'd6);
      set_in(1, 0, 0); tick();
      set_in(1, 1, 0); tick();
      repeat (3) tick();
      chk("t3_active", int'(bus.gen_enable), 1);
      load_cfg(8'd7, 16'd0, 16'd2);
      chk("t3_rate_held", int'(bus.gen_rate), 3);
      bus.gen_strobe = 1'b1;
      repeat (6) tick();
      bus.gen_strobe = 1'b0;
      chk("t3_done", int'(bus.window_done), 1);
      chk("t3_rate_still", int'(bus.gen_rate), 3);
      set_in(1, 0, 0); tick();
      bus.cfg_load = 1'b1; bus.cfg_rate = 8'd9; bus.cfg_delay = 16'd0; bus.cfg_samples = 16'd1;
      set_in(1, 1, 0); tick();
      chk("t3_rate_new", int'(bus.gen_rate), 7);
      chk("t3_old_delay", int'(bus.gen_enable), 1);

      // Enable drop mid-ACTIVE, then a suppressed (zero-sample) window.
      bus.gen_strobe = 1'b1; tick();
      set_in(0, 1, 1); tick();
      chk("t5_gen_enable", int'(bus.gen_enable), 0);
      chk("t5_no_done", int'(bus.window_done), 0);
      chk("t5_count", int'(bus.windows_count), 4);
      chk("t5_rate_held", int'(bus.gen_rate), 7);
      set_in(1, 1, 0); tick();
      load_cfg(8'd5, 16'd3, 16'd0);
      set_in(1, 0, 0); tick();
      set_in(1, 1, 0); tick();
      repeat (4) tick();
      chk("t5_zero_enable", int'(bus.gen_enable), 0);
      chk("t5_zero_active", int'(bus.window_active), 0);
      chk("t5_zero_overrun", int'(bus.overrun), 0);

      // Overrun during DELAY, clear, and set-beats-clear.
      load_cfg(8'd4, 16'd20, 16'd2);
      set_in(1, 0, 0); tick();
      set_in(1, 1, 0); tick(); k = 1;
      set_in(1, 0, 0); tick(); k++;
      set_in(1, 1, 0); tick(); k++;
      chk("t4_overrun_set", int'(bus.overrun), 1);
      while (!bus.gen_enable && k < 60) begin tick(); k++; end
      chk("t4_latency", k, 21);
      bus.overrun_clr = 1'b1; tick();
      chk("t4_overrun_clr", int'(bus.overrun), 0);
      set_in(1, 0, 0); tick();
      bus.overrun_clr = 1'b1;
      set_in(1, 1, 0); tick();
      chk("t4_set_wins", int'(bus.overrun), 1);
      bus.gen_strobe = 1'b1; tick(); tick();
      bus.gen_strobe = 1'b0;
      chk("t4_done", int'(bus.window_done), 1);
      chk("t4_count", int'(bus.windows_count), 5);

      // Counter wrap on the 8-bit instance with back-to-back one-strobe windows.
      wbus.ctrl_enable = 1'b1;
      wbus.cfg_load = 1'b1; wbus.cfg_delay = '0; wbus.cfg_samples = 8'd1; wbus.cfg_rate = 8'd1;
      tick();
      wbus.cfg_load = 1'b0;
      wbus.gen_strobe = 1'b1;
      for (int w = 0; w < 256; w++) begin
         wbus.sync_in = 1'b1; tick();
         wbus.sync_in = 1'b0; tick();
         if (w == 254) chk("t6_count_max", int'(wbus.windows_count), 255);
      end
      chk("t6_wrap", int'(wbus.windows_count), 0);
      wbus.ctrl_enable = 1'b0;
      wbus.gen_strobe = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         bus.ctrl_enable = ($urandom_range(0, 99) < 97);
         if ($urandom_range(0, 7) == 0) bus.sync_in = ~bus.sync_in;
         bus.gen_strobe = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) begin
            bus.cfg_load = 1'b1;
            bus.cfg_rate = 8'($urandom);
            bus.cfg_delay = 16'($urandom_range(0, 6));
            bus.cfg_samples = 16'($urandom_range(0, 5));
         end
         bus.overrun_clr = ($urandom_range(0, 19) == 0);
         tick();
      end

      // Reset in the middle of an active window.
      set_in(0, 0, 0); tick();
      set_in(1, 0, 0); tick();
      load_cfg(8'd2, 16'd3, 16'd3);
      set_in(1, 1, 0); tick();
      repeat (3) tick();
      chk("rw_active", int'(bus.gen_enable), 1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("rw_gen_enable", int'(bus.gen_enable), 0);
      chk("rw_active_clr", int'(bus.window_active), 0);
      chk("rw_count", int'(bus.windows_count), 0);
      chk("rw_rate", int'(bus.gen_rate), 0);
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
